// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the 5-stage pipeline datapath and the hazard controller.
// The datapath (master) reports decode/execute/memory status and receives the
// stall/flush controls plus performance/error status from the controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Decode-stage operand usage
  logic [4:0]       F_D_rs1_index;
  logic [4:0]       F_D_rs2_index;
  logic             F_D_rs1_used;
  logic             F_D_rs2_used;
  // Execute-stage status
  logic [4:0]       D_E_rd_index;
  logic             D_E_is_load;
  logic             E_branch_taken;
  // Memory-stage handshake
  logic             dmem_req;
  logic             dmem_ready;
  // Pipeline controls
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             flush_F;
  logic             flush_D;
  // Status
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output F_D_rs1_index, F_D_rs2_index, F_D_rs1_used, F_D_rs2_used,
    output D_E_rd_index, D_E_is_load, E_branch_taken,
    output dmem_req, dmem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_F, flush_D,
    input  mem_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  F_D_rs1_index, F_D_rs2_index, F_D_rs1_used, F_D_rs2_used,
    input  D_E_rd_index, D_E_is_load, E_branch_taken,
    input  dmem_req, dmem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_F, flush_D,
    output mem_timeout_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard-resolution controller: generates stall/freeze/flush for hazards the
// forwarding network cannot cover (load-use, data-memory wait, taken redirect),
// with saturating stall/flush counters and a sticky memory-timeout error.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned WAIT_W      = 8,   // must be wide enough to hold MEM_TIMEOUT
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [0:0]        StRun      = 1'b0;
  localparam logic [0:0]        StMemWait  = 1'b1;
  localparam logic [WAIT_W-1:0] TimeoutVal = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic timeout_hit;
  logic mem_done;
  logic freeze;
  logic rs1_hit, rs2_hit, load_use;
  logic stall_f, stall_d, stall_e, stall_m, flush_f, flush_d;

  // Waiting on memory ends on ready; a dropped request also ends the wait.
  assign mem_done    = hz.dmem_ready | ~hz.dmem_req;
  assign timeout_hit = (state_q == StMemWait) && (wait_cnt_q == TimeoutVal);

  // Load-use: decode reads the register a load in execute is about to write.
  // x0 is hard-wired zero, so it can never carry a dependency.
  assign rs1_hit  = hz.F_D_rs1_used && (hz.F_D_rs1_index == hz.D_E_rd_index);
  assign rs2_hit  = hz.F_D_rs2_used && (hz.F_D_rs2_index == hz.D_E_rd_index);
  assign load_use = hz.D_E_is_load && (hz.D_E_rd_index != 5'd0) && (rs1_hit || rs2_hit);

  // Freeze the whole pipeline while the memory stage is waiting; the ready
  // cycle itself is never frozen so a single-cycle access adds no latency.
  always_comb begin
    freeze = 1'b0;
    unique case (state_q)
      StRun:     freeze = hz.dmem_req & ~hz.dmem_ready;
      StMemWait: freeze = ~mem_done & ~timeout_hit;
      default:   freeze = 1'b0;
    endcase
  end

  // FSM next state, wait counter and sticky timeout error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StRun: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_done) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          // Forced release: let the pipeline move and flag the error.
          state_d = StRun;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Prioritised control outputs: freeze > redirect > load-use; all low in reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_f = 1'b0;
    flush_d = 1'b0;
    if (!rst) begin
      // Held inactive for the whole reset.
    end else if (freeze) begin
      // Pending redirect or load-use is held and acted on after the wait.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (hz.E_branch_taken) begin
      // The dependent instruction is killed, so load-use is moot.
      flush_f = 1'b1;
      flush_d = 1'b1;
    end else if (load_use) begin
      // One bubble; next cycle the load is in M and forwarding takes over.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_d = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush_f && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_F         = stall_f;
  assign hz.stall_D         = stall_d;
  assign hz.stall_E         = stall_e;
  assign hz.stall_M         = stall_m;
  assign hz.flush_F         = flush_f;
  assign hz.flush_D         = flush_d;
  assign hz.mem_timeout_err = err_q;
  assign hz.stall_cycles    = stall_cnt_q;
  assign hz.flush_events    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .WAIT_W     (8),
    .CNT_W      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [5:0]  ctrl;   // {stall_F, stall_D, stall_E, stall_M, flush_F, flush_D}
    logic        err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;

  // Model state: frozen cycles spent on the current memory access, sticky error,
  // and unbounded event totals (saturation applied only when predicting).
  int m_frozen    = 0;
  bit m_err       = 1'b0;
  int m_stall_tot = 0;
  int m_flush_tot = 0;

  function automatic logic [CW-1:0] sat(input int v);
    return (v > CMAX) ? CW'(CMAX) : CW'(v);
  endfunction

  // One pipeline cycle: drive inputs just after the edge and predict outputs.
  task automatic cyc(input bit r, input bit req, input bit rdy, input bit br,
                     input bit ld, input int rd, input int rs1, input bit u1,
                     input int rs2, input bit u2);
    exp_t e;
    bit   frz, lu, timed_out;
    bit   sf, sd, se, sm, ff, fd;
    @(posedge clk);
    #1;
    rst                = r;
    bus.dmem_req       = req;
    bus.dmem_ready     = rdy;
    bus.E_branch_taken = br;
    bus.D_E_is_load    = ld;
    bus.D_E_rd_index   = 5'(rd);
    bus.F_D_rs1_index  = 5'(rs1);
    bus.F_D_rs1_used   = u1;
    bus.F_D_rs2_index  = 5'(rs2);
    bus.F_D_rs2_used   = u2;
    step++;
    e.id = step;
    if (!r) begin
      m_frozen    = 0;
      m_err       = 1'b0;
      m_stall_tot = 0;
      m_flush_tot = 0;
      e.ctrl = '0; e.err = 1'b0; e.sc = '0; e.fe = '0;
      exp_q.push_back(e);
      return;
    end
    timed_out = 1'b0;
    if (m_frozen == 0)              frz = req && !rdy;
    else if (!req || rdy)           frz = 1'b0;
    else if (m_frozen == TO + 1) begin
      frz = 1'b0;
      timed_out = 1'b1;
    end else                        frz = 1'b1;
    lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    {sf, sd, se, sm, ff, fd} = 6'b0;
    if (frz)     {sf, sd, se, sm} = 4'b1111;
    else if (br) {ff, fd} = 2'b11;
    else if (lu) {sf, sd, fd} = 3'b111;
    e.ctrl = {sf, sd, se, sm, ff, fd};
    e.err  = m_err;
    e.sc   = sat(m_stall_tot);
    e.fe   = sat(m_flush_tot);
    exp_q.push_back(e);
    m_frozen    = frz ? m_frozen + 1 : 0;
    if (timed_out) m_err = 1'b1;
    m_stall_tot += int'(sf);
    m_flush_tot += int'(ff);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = exp_q.pop_front();
      act = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M, bus.flush_F, bus.flush_D};
      checks += 4;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL step %0d ctrl actual=%b required=%b", e.id, act, e.ctrl);
      end
      if (bus.mem_timeout_err !== e.err) begin
        failures++;
        $display("FAIL step %0d mem_timeout_err actual=%b required=%b", e.id,
                 bus.mem_timeout_err, e.err);
      end
      if (bus.stall_cycles !== e.sc) begin
        failures++;
        $display("FAIL step %0d stall_cycles actual=%0d required=%0d", e.id,
                 bus.stall_cycles, e.sc);
      end
      if (bus.flush_events !== e.fe) begin
        failures++;
        $display("FAIL step %0d flush_events actual=%0d required=%0d", e.id,
                 bus.flush_events, e.fe);
      end
    end
  end

  initial begin
    bit prev_req, prev_rdy;
    bit r, req, rdy;
    rst = 1'b0;
    bus.dmem_req = 0; bus.dmem_ready = 0; bus.E_branch_taken = 0; bus.D_E_is_load = 0;
    bus.D_E_rd_index = 0; bus.F_D_rs1_index = 0; bus.F_D_rs2_index = 0;
    bus.F_D_rs1_used = 0; bus.F_D_rs2_used = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Load-use on rs2 for one cycle, then clears
    cyc(1, 0, 0, 0, 1, 5, 1, 1, 5, 1);
    idle(2);
    // No false hazard: rd=0 with rs1=0; rd=7 on unused rs2
    cyc(1, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 7, 3, 1, 7, 0);
    // Branch beats load-use
    cyc(1, 0, 0, 1, 1, 9, 9, 1, 2, 0);
    idle(1);
    // Memory wait of 3 cycles with a redirect held throughout
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Zero-latency access
    cyc(1, 1, 1, 0, 1, 4, 4, 1, 0, 0);
    idle(1);
    // Timeout with ready held low, then re-entry, then request dropped
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Stall counter saturation via persistent load-use
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 3, 3, 1, 0, 0);
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Reset mid-wait, then an immediate-ready access
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Random traffic; requests tend to persist while waiting
    prev_req = 0; prev_rdy = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 149) != 0);
      if (prev_req && !prev_rdy) req = ($urandom_range(0, 9) != 0);
      else                       req = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      cyc(r, req, rdy, ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1));
      prev_req = req;
      prev_rdy = rdy;
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard-resolution controller for the 5-stage RISC-V pipeline; the stall/flush side of the forwarding path.
- Forwarding resolves only the data hazards that a bypass can cover. This block generates stall, freeze and flush for the hazards a bypass cannot cover:
  - load-use dependency,
  - variable-latency data-memory wait,
  - taken branch/jump redirect.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before forced release.
- WAIT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- F_D_rs1_index  input  5  rs1 of the instruction in decode.
- F_D_rs2_index  input  5  rs2 of the instruction in decode.
- F_D_rs1_used  input  1  decode instruction reads rs1.
- F_D_rs2_used  input  1  decode instruction reads rs2.
- D_E_rd_index  input  5  rd of the instruction in execute.
- D_E_is_load  input  1  execute instruction is a load.
- E_branch_taken  input  1  execute resolved a taken branch/jump.
- dmem_req  input  1  memory stage has an active load/store.
- dmem_ready  input  1  data memory completes the access this cycle.
- stall_F  output  1  hold PC.
- stall_D  output  1  hold the F_D register.
- stall_E  output  1  hold the D_E register.
- stall_M  output  1  hold the E_M register.
- flush_F  output  1  clear F_D (insert NOP).
- flush_D  output  1  clear D_E (insert bubble).
- mem_timeout_err  output  1  sticky; set on timeout.
- stall_cycles  output  CNT_W  count of cycles with stall_F=1.
- flush_events  output  CNT_W  count of cycles with flush_F=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, wait_cnt=0, counters=0, mem_timeout_err=0.
  - All stall/flush outputs forced to 0 while rst=0.
- FSM states: RUN, MEM_WAIT. State is registered; control outputs are combinational from state and inputs.
- freeze = (RUN & dmem_req & ~dmem_ready) | (MEM_WAIT & ~dmem_ready & ~timeout_hit).
  - timeout_hit = (wait_cnt == MEM_TIMEOUT).
- Transitions:
  - RUN -> MEM_WAIT when dmem_req & ~dmem_ready.
  - MEM_WAIT -> RUN when dmem_ready.
  - MEM_WAIT -> RUN when timeout_hit; in that same cycle set mem_timeout_err.
- wait_cnt:
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle in MEM_WAIT while ~dmem_ready.
- dmem_req must stay high throughout MEM_WAIT. If it drops, treat it as dmem_ready.
- The ready cycle is not frozen: zero added latency when dmem_ready coincides with dmem_req in RUN.
- Load-use detection:
  - lu = D_E_is_load & D_E_rd_index != 0 & ((F_D_rs1_used & rs1 == rd) | (F_D_rs2_used & rs2 == rd)).
  - Index 0 never creates a hazard.
- Output priority, highest first:
  1. freeze: stall_F = stall_D = stall_E = stall_M = 1; flush_F = flush_D = 0. A pending branch or load-use is held, not acted on.
  2. E_branch_taken: flush_F = flush_D = 1; no stalls. Load-use is ignored because the dependent instruction is killed.
  3. lu: stall_F = stall_D = 1 and flush_D = 1 for exactly one cycle. On the next cycle the load has advanced to M, so the hazard clears naturally and forwarding covers it.
  4. Otherwise all outputs 0.
- Counters:
  - Increment at the clock edge when their source output is 1.
  - Saturate at all-ones; no wrap.
- mem_timeout_err is cleared only by reset.
- Reset asserted mid-MEM_WAIT: returns to RUN immediately; wait_cnt cleared.

Test Plan:
- Load-use: D_E_is_load=1, D_E_rd_index=5, F_D_rs2_index=5, rs2_used=1, one cycle -> stall_F=stall_D=flush_D=1 that cycle, 0 next; stall_cycles=1.
- No false hazard:
  - rd=0 with rs1=0 -> no stall.
  - rd=7 matching rs2 but rs2_used=0 -> no stall.
- Branch beats load-use: lu condition plus E_branch_taken=1 -> flush_F=flush_D=1, stall_F=0; flush_events=1.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> all four stalls=1 for exactly 3 cycles, 0 on the ready cycle; a branch_taken held during the wait flushes only on the ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> freeze released after 5 frozen cycles, mem_timeout_err=1 and stays 1; counter saturation checked with CNT_W=4 (stall_cycles stops at 15).
- Reset mid-wait: rst pulsed low during MEM_WAIT -> outputs 0 asynchronously, counters 0, next access with immediate ready causes no stall.
